// File: rtl/seq_pkg.sv
// Shared types and constants for the CNN bring-up sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMem  = 3'd1,
    StPe   = 3'd2,
    StP3   = 3'd3,
    StP2   = 3'd4,
    StDisp = 3'd5,
    StErr  = 3'd6
  } state_e;

  localparam int unsigned STG_MEM    = 0;
  localparam int unsigned STG_PE     = 1;
  localparam int unsigned STG_P3     = 2;
  localparam int unsigned STG_P2     = 3;
  localparam int unsigned STG_DISP   = 4;
  localparam int unsigned NUM_STAGES = 5;

  function automatic logic is_stage(state_e s);
    return (s == StMem) || (s == StPe) || (s == StP3) || (s == StP2);
  endfunction

  // Stage states are laid out contiguously starting at StMem.
  function automatic logic [1:0] stage_idx(state_e s);
    logic [2:0] d;
    d = s - StMem;
    return d[1:0];
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Run-control / datapath handshake bundle for stage_sequencer.
interface stage_sequencer_if;
  logic       start;
  logic       abort;
  logic [3:0] stage_done;
  logic [4:0] stage_en;
  logic [3:0] stage_start;
  logic       busy;
  logic       run_done;
  logic       err;
  logic [1:0] err_stage;
  logic [2:0] state;

  modport master (
    output start, abort, stage_done,
    input  stage_en, stage_start, busy, run_done, err, err_stage, state
  );

  modport slave (
    input  start, abort, stage_done,
    output stage_en, stage_start, busy, run_done, err, err_stage, state
  );
endinterface

// File: rtl/seq_watchdog.sv
// Per-stage watchdog: saturating cycle counter with clear/enable and a terminal-count pulse.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_W = 32,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = en && (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Handshake bring-up sequencer for the CNN stage chain (mem, pe, pool3, pool2, disp).
// Define SEQ_TIMEOUT_EN to build the per-stage watchdog and the ERR path.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 32,
  parameter int unsigned TIMEOUT   = 100000
) (
  input logic               clk,
  input logic               rst,
  stage_sequencer_if.slave  bus
);

  state_e                  state_q, state_d;
  logic [NUM_STAGES-1:0]   stage_en_q, stage_en_d;
  logic [3:0]              stage_start_q, stage_start_d;
  logic                    busy_q, busy_d;
  logic                    run_done_q, run_done_d;
  logic                    err_q, err_d;
  logic [1:0]              err_stage_q, err_stage_d;
  logic [1:0]              cur;
  logic                    cur_done;
  logic                    timeout;

  assign cur      = stage_idx(state_q);
  assign cur_done = bus.stage_done[cur];

`ifdef SEQ_TIMEOUT_EN
  seq_watchdog #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d != state_q),
    .en      (is_stage(state_q)),
    .timeout (timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_W'(TIMEOUT);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    stage_en_d    = stage_en_q;
    stage_start_d = '0;
    run_done_d    = 1'b0;
    err_d         = err_q;
    err_stage_d   = err_stage_q;

    if (bus.abort) begin
      state_d     = StIdle;
      stage_en_d  = '0;
      err_d       = 1'b0;
      err_stage_d = '0;
    end else if (is_stage(state_q)) begin
      // Done beats a same-cycle timeout.
      if (cur_done) begin
        if (cur == 2'(STG_P2)) begin
          state_d              = StDisp;
          stage_en_d[STG_DISP] = 1'b1;
          run_done_d           = 1'b1;
        end else begin
          state_d                            = state_e'(state_q + 3'd1);
          stage_en_d[3'(cur) + 3'd1]         = 1'b1;
          stage_start_d[cur + 2'd1]          = 1'b1;
        end
      end else if (timeout) begin
        state_d     = StErr;
        stage_en_d  = '0;
        err_d       = 1'b1;
        err_stage_d = cur;
      end
    end else if (bus.start) begin
      // Restart clears the downstream enables, flushing the chain.
      state_d                = StMem;
      stage_en_d             = '0;
      stage_en_d[STG_MEM]    = 1'b1;
      stage_start_d[STG_MEM] = 1'b1;
      err_d                  = 1'b0;
      err_stage_d            = '0;
    end

    busy_d = is_stage(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      stage_en_q    <= '0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      err_q         <= 1'b0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      stage_en_q    <= stage_en_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      run_done_q    <= run_done_d;
      err_q         <= err_d;
      err_stage_q   <= err_stage_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.stage_en    = stage_en_q;
  assign bus.stage_start = stage_start_q;
  assign bus.busy        = busy_q;
  assign bus.run_done    = run_done_q;
  assign bus.err         = err_q;
  assign bus.err_stage   = err_stage_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: reference model predicts per-cycle outputs, monitor compares.
module tb_stage_sequencer;

  localparam int unsigned TO = 16;
`ifdef SEQ_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  stage_sequencer_if sif ();

  stage_sequencer #(
    .TIMEOUT_W (32),
    .TIMEOUT   (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic [4:0] en;
    logic [3:0] sst;
    logic       busy;
    logic       rd;
    logic       err;
    logic [1:0] es;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: state as a plain number, enables as a prefix mask of that number.
  int       m_state = 0;
  int       m_cnt   = 0;
  int       m_es    = 0;
  bit       m_err   = 1'b0;
  int       nst;
  int       k;
  bit       in_stage;
  bit [3:0] sst;
  bit       rd;
  exp_t     e;

  always @(posedge clk) begin
    nst      = m_state;
    sst      = '0;
    rd       = 1'b0;
    in_stage = (m_state >= 1) && (m_state <= 4);
    k        = in_stage ? m_state - 1 : 0;
    if (rst) begin
      nst = 0; m_err = 1'b0; m_es = 0;
    end else if (sif.abort) begin
      nst = 0; m_err = 1'b0; m_es = 0;
    end else if (in_stage && sif.stage_done[k]) begin
      nst = m_state + 1;
      if (k < 3) sst[k+1] = 1'b1;
      else rd = 1'b1;
    end else if (in_stage && WD && (m_cnt == TO - 1)) begin
      nst = 6; m_err = 1'b1; m_es = k;
    end else if (!in_stage && sif.start) begin
      nst = 1; sst[0] = 1'b1; m_err = 1'b0; m_es = 0;
    end
    if (rst || (nst != m_state)) m_cnt = 0;
    else if (in_stage) m_cnt = m_cnt + 1;
    m_state = nst;

    e.state = 3'(nst);
    e.en    = (nst >= 1 && nst <= 5) ? 5'((1 << nst) - 1) : 5'd0;
    e.sst   = sst;
    e.busy  = (nst >= 1) && (nst <= 4);
    e.rd    = rd;
    e.err   = m_err;
    e.es    = 2'(m_es);
    q.push_back(e);
  end

  task automatic chk(input string name, input int act, input int exp, input exp_t unused_e);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  exp_t c;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      c = q.pop_front();
      chk("state",       int'(sif.state),       int'(c.state), c);
      chk("stage_en",    int'(sif.stage_en),    int'(c.en),    c);
      chk("stage_start", int'(sif.stage_start), int'(c.sst),   c);
      chk("busy",        int'(sif.busy),        int'(c.busy),  c);
      chk("run_done",    int'(sif.run_done),    int'(c.rd),    c);
      chk("err",         int'(sif.err),         int'(c.err),   c);
      chk("err_stage",   int'(sif.err_stage),   int'(c.es),    c);
    end
  end

  task automatic cyc(input bit s, input bit a, input logic [3:0] d);
    sif.start      = s;
    sif.abort      = a;
    sif.stage_done = d;
    @(posedge clk);
    #1;
  endtask

  bit       rs, ra, rr;
  logic [3:0] rdn;

  initial begin
    sif.start      = 1'b0;
    sif.abort      = 1'b0;
    sif.stage_done = '0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Full run, each done a few cycles after its start strobe.
    cyc(1, 0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 4'h0);
      cyc(0, 0, 4'h0);
      cyc(0, 0, 4'(1 << i));
    end
    cyc(0, 0, 4'h0);
    cyc(0, 0, 4'h0);

    // Re-run from DISP with done held high: fastest path.
    cyc(1, 0, 4'hF);
    repeat (6) cyc(0, 0, 4'hF);

    // Abort in P3 coinciding with its done.
    cyc(0, 1, 4'h0);
    cyc(1, 0, 4'h0);
    cyc(0, 0, 4'b0001);
    cyc(0, 0, 4'b0010);
    cyc(0, 1, 4'b0100);
    cyc(0, 0, 4'h0);

    // Start and stray done while in PE, then PE stalls (watchdog in that build).
    cyc(1, 0, 4'h0);
    cyc(0, 0, 4'b0001);
    cyc(1, 0, 4'h0);
    cyc(0, 0, 4'b1000);
    repeat (20) cyc(0, 0, 4'h0);
    cyc(1, 0, 4'h0);
    cyc(0, 0, 4'h0);
    cyc(0, 1, 4'h0);

    // Randomized traffic with occasional abort and reset.
    repeat (3000) begin
      rs  = ($urandom_range(7) == 0);
      ra  = ($urandom_range(39) == 0);
      rr  = ($urandom_range(499) == 0);
      rdn = 4'($urandom) & 4'($urandom);
      rst = rr;
      cyc(rs, ra, rdn);
    end
    rst = 1'b0;
    cyc(0, 0, 4'h0);
    cyc(0, 0, 4'h0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
